// File: rtl/gpr_predcd_regfile_pkg.sv
// Shared constants, predecoded-address type and field helpers for the GPR file.
// The optional write-through forwarding is enabled with GPR_WR_BYPASS_EN.
package p405s_gpr_pkg;

  localparam int GPR_PREDCD_W = 10;
  localparam int GPR_NUM      = 32;
  localparam int GPR_DATA_W   = 32;

  localparam int MSB_LO  = 0;
  localparam int MSB_HI  = 1;
  localparam int HI_BASE = 2;
  localparam int LO_BASE = 6;

  typedef logic [0:GPR_PREDCD_W-1] gpr_predcd_t;

  function automatic logic is_onehot2(input logic [0:1] v);
    return v[0] ^ v[1];
  endfunction

  function automatic logic is_onehot4(input logic [0:3] v);
    case (v)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpr_predcd_regfile_sel.sv
// Final decode of a predecoded GPR address into a one-hot register select
// plus a well-formed flag.
module gpr_predcd_sel
  import p405s_gpr_pkg::*;
(
  input  gpr_predcd_t          predcd,
  output logic [GPR_NUM-1:0]   sel,
  output logic                 wf
);

  // AND of one term from each predecode field selects register n
  always_comb begin
    sel = '0;
    for (int n = 0; n < GPR_NUM; n++) begin
      logic [4:0] idx_s;
      idx_s  = 5'(n);
      sel[n] = predcd[MSB_LO + int'(idx_s[4])]
             & predcd[HI_BASE + int'(idx_s[3:2])]
             & predcd[LO_BASE + int'(idx_s[1:0])];
    end
  end

  // each field must be exactly one-hot for the address to be usable
  always_comb begin
    wf = is_onehot2(predcd[MSB_LO:MSB_HI])
       & is_onehot4(predcd[HI_BASE:HI_BASE+3])
       & is_onehot4(predcd[LO_BASE:LO_BASE+3]);
  end

endmodule

// File: rtl/gpr_predcd_regfile.sv
// 32-entry GPR file with two registered read ports and one write port, driven
// by predecoded addresses. Define GPR_WR_BYPASS_EN for same-cycle write forwarding.
module gpr_predcd_regfile
  import p405s_gpr_pkg::*;
#(
  parameter int DATA_W  = GPR_DATA_W,
  parameter int NUM_GPR = GPR_NUM
) (
  input  logic              CB,
  input  logic              resetCore_n,
  input  logic              rdHold,
  input  gpr_predcd_t       rdAPreDcd,
  input  gpr_predcd_t       rdBPreDcd,
  input  logic              rdAVld,
  input  logic              rdBVld,
  input  gpr_predcd_t       wrPreDcd,
  input  logic              wrEn,
  input  logic [0:DATA_W-1] wrData,
  output logic [0:DATA_W-1] rdAData,
  output logic [0:DATA_W-1] rdBData,
  output logic              rdAValid,
  output logic              rdBValid,
  output logic              preDcdErr
);

  logic [0:DATA_W-1]  gpr_r [NUM_GPR];
  logic [GPR_NUM-1:0] ra_sel_s, rb_sel_s, wr_sel_s;
  logic               ra_wf_s, rb_wf_s, wr_wf_s;
  logic               wr_ok_s, ra_ok_s, rb_ok_s, err_s;
  logic [0:DATA_W-1]  ra_mux_s, rb_mux_s, ra_next_s, rb_next_s;

  gpr_predcd_sel u_sel_ra (.predcd(rdAPreDcd), .sel(ra_sel_s), .wf(ra_wf_s));
  gpr_predcd_sel u_sel_rb (.predcd(rdBPreDcd), .sel(rb_sel_s), .wf(rb_wf_s));
  gpr_predcd_sel u_sel_wr (.predcd(wrPreDcd),  .sel(wr_sel_s), .wf(wr_wf_s));

  // request qualification and malformed-address detection
  always_comb begin
    wr_ok_s = wrEn   & wr_wf_s;
    ra_ok_s = rdAVld & ra_wf_s;
    rb_ok_s = rdBVld & rb_wf_s;
    err_s   = (wrEn & ~wr_wf_s) | (rdAVld & ~ra_wf_s) | (rdBVld & ~rb_wf_s);
  end

  // one-hot AND-OR read muxes
  always_comb begin
    ra_mux_s = '0;
    rb_mux_s = '0;
    for (int n = 0; n < NUM_GPR; n++) begin
      ra_mux_s = ra_mux_s | (gpr_r[n] & {DATA_W{ra_sel_s[n]}});
      rb_mux_s = rb_mux_s | (gpr_r[n] & {DATA_W{rb_sel_s[n]}});
    end
  end

  // next read-port values, optionally forwarding a colliding write
  always_comb begin
    ra_next_s = ra_ok_s ? ra_mux_s : '0;
    rb_next_s = rb_ok_s ? rb_mux_s : '0;
`ifdef GPR_WR_BYPASS_EN
    if (ra_ok_s && wr_ok_s && ((ra_sel_s & wr_sel_s) != '0)) begin
      ra_next_s = wrData;
    end else begin
      ra_next_s = ra_next_s;
    end
    if (rb_ok_s && wr_ok_s && ((rb_sel_s & wr_sel_s) != '0)) begin
      rb_next_s = wrData;
    end else begin
      rb_next_s = rb_next_s;
    end
`endif
  end

  // register array write-back
  always_ff @(posedge CB) begin
    if (!resetCore_n) begin
      for (int n = 0; n < NUM_GPR; n++) gpr_r[n] <= '0;
    end else if (wr_ok_s) begin
      for (int n = 0; n < NUM_GPR; n++) begin
        if (wr_sel_s[n]) gpr_r[n] <= wrData;
      end
    end
  end

  // read pipeline registers; hold freezes data and valid but not the error flag
  always_ff @(posedge CB) begin
    if (!resetCore_n) begin
      rdAData   <= '0;
      rdBData   <= '0;
      rdAValid  <= 1'b0;
      rdBValid  <= 1'b0;
      preDcdErr <= 1'b0;
    end else begin
      preDcdErr <= preDcdErr | err_s;
      if (!rdHold) begin
        rdAData  <= ra_next_s;
        rdBData  <= rb_next_s;
        rdAValid <= ra_ok_s;
        rdBValid <= rb_ok_s;
      end
    end
  end

endmodule
